// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low hex glyphs,
// the blank pattern and a width helper for counters and indices.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment driver with PWM brightness and frame-aligned,
// double-buffered loading so a display update never tears mid-frame.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 100000,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_sync,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int PRE_W = idx_w(PRESCALE);
    localparam int IDX_W = idx_w(NUM_DIGITS);
    localparam int STEP  = PRESCALE >> BRIGHT_BITS;

    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_BITS-1:0]  bright_q;

    logic [4*NUM_DIGITS-1:0] pending_data, active_data;
    logic [NUM_DIGITS-1:0]   pending_dp, active_dp;
    logic [NUM_DIGITS-1:0]   pending_en, active_en;
    logic                    pending_valid;

    logic                    tick, frame_end, lit;
    logic [31:0]             on_time;
    logic [3:0]              cur_nibble;
    logic                    cur_dp, cur_en;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   anode_next;

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign on_time   = (32'(bright_q) + 32'd1) * 32'(STEP);

    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble = active_data[4*i +: 4];
                cur_dp     = active_dp[i];
                cur_en     = active_en[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    // A blanked slot keeps its full length so the scan rate never depends on content
    always_comb begin
        lit = cur_en && (32'(pre_cnt) < on_time);
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_next[i] = ~(lit && (idx == IDX_W'(i)));
        end
    end

    // Commit and load share a cycle: the commit takes the old pending copy
    // before the load overwrites it and re-arms pending_valid.
    always_ff @(posedge clkin) begin
        if (reset) begin
            pre_cnt       <= '0;
            idx           <= '0;
            bright_q      <= '0;
            pending_data  <= '0;
            pending_dp    <= '0;
            pending_en    <= '0;
            pending_valid <= 1'b0;
            active_data   <= '0;
            active_dp     <= '0;
            active_en     <= '0;
            load_ack      <= 1'b0;
            frame_sync    <= 1'b0;
            anode         <= '1;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                idx      <= frame_end ? '0 : idx + 1'b1;
                bright_q <= brightness;
            end

            frame_sync <= frame_end;
            load_ack   <= frame_end && pending_valid;

            if (frame_end && pending_valid) begin
                active_data   <= pending_data;
                active_dp     <= pending_dp;
                active_en     <= pending_en;
                pending_valid <= 1'b0;
            end
            if (load) begin
                pending_data  <= data_in;
                pending_dp    <= dp_in;
                pending_en    <= digit_en;
                pending_valid <= 1'b1;
            end

            anode <= anode_next;
            seg   <= lit ? cur_seg : SEG_BLANK;
            dp    <= lit ? ~cur_dp : 1'b1;
        end
    end

endmodule
